stacker_matrix_scan: RTL and testbench

Row-multiplexed driver for the 8x8 LED matrix that shows the stacker playfield. It consumes the 64-bit `game_display` frame produced by the game logic and scans it onto the matrix one row at a time, with a blanking gap between rows. New frames are double-buffered so a frame is never torn mid-scan. When the game signals end-of-game, the whole image blinks.

---
 rtl/stacker_matrix_scan_if.sv | 19 +
 rtl/stacker_matrix_scan.sv | 155 +++++++++++++++
 tb/tb_stacker_matrix_scan.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/stacker_matrix_scan_if.sv
// Frame/blink inputs and matrix drive outputs of the stacker LED scanner.
interface stacker_matrix_scan_if;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        blink_en;
  logic [7:0]  row_n;
  logic [7:0]  col;
  logic        frame_sync;

  modport master (
    output frame_in, frame_valid, blink_en,
    input  row_n, col, frame_sync
  );

  modport slave (
    input  frame_in, frame_valid, blink_en,
    output row_n, col, frame_sync
  );
endinterface

// File: rtl/stacker_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver: double-buffered frames, blanking
// gap between rows, and whole-image blinking for end-of-game.
module stacker_matrix_scan #(
  parameter int unsigned DWELL        = 1024,
  parameter int unsigned BLANK        = 8,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  stacker_matrix_scan_if.slave bus
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_row, w_row_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_boundary;

  logic [63:0]        r_pending, w_pending_nxt;
  logic               r_pend_vld, w_pend_vld_nxt;
  logic [63:0]        r_shadow, w_shadow_nxt;
  logic [BLK_W-1:0]   r_blink_cnt, w_blink_cnt_nxt;
  logic               r_blink_off, w_blink_off_nxt;

  logic [7:0]         r_row_n, w_row_n_nxt;
  logic [7:0]         r_col, w_col_nxt;
  logic               r_frame_sync, w_frame_sync_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_BLANK;
      r_row   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: blank/drive phase timing and row advance
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_boundary  = 1'b0;
    case (r_state)
      S_BLANK: begin
        if (r_cnt == CNT_W'(BLANK - 1)) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      S_DRIVE: begin
        if (r_cnt == CNT_W'(DWELL - 1)) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          if (r_row == 3'd7) begin
            w_row_nxt  = 3'd0;
            w_boundary = 1'b1;
          end else begin
            w_row_nxt  = r_row + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Frame double-buffer and blink phase; both only move at frame boundaries
  always_comb begin
    w_pending_nxt   = r_pending;
    w_pend_vld_nxt  = r_pend_vld;
    w_shadow_nxt    = r_shadow;
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_off_nxt = r_blink_off;

    if (bus.frame_valid) begin
      w_pending_nxt  = bus.frame_in;
      w_pend_vld_nxt = 1'b1;
    end
    if (w_boundary) begin
      if (bus.frame_valid) begin
        w_shadow_nxt   = bus.frame_in;
        w_pend_vld_nxt = 1'b0;
      end else if (r_pend_vld) begin
        w_shadow_nxt   = r_pending;
        w_pend_vld_nxt = 1'b0;
      end
    end

    if (!bus.blink_en) begin
      w_blink_cnt_nxt = '0;
      w_blink_off_nxt = 1'b0;
    end else if (w_boundary) begin
      if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        w_blink_cnt_nxt = '0;
        w_blink_off_nxt = ~r_blink_off;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BLK_W'(1);
      end
    end
  end

  // Output decode from next state so the registered outputs line up with it
  always_comb begin
    w_row_n_nxt      = 8'hFF;
    w_col_nxt        = 8'h00;
    w_frame_sync_nxt = (w_state_nxt == S_BLANK) && (w_row_nxt == 3'd0) &&
                       (w_cnt_nxt == '0);
    if (w_state_nxt == S_DRIVE) begin
      w_row_n_nxt = ~(8'd1 << w_row_nxt);
      if (!w_blink_off_nxt) begin
        w_col_nxt = w_shadow_nxt[{w_row_nxt, 3'b000} +: 8];
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending    <= '0;
      r_pend_vld   <= 1'b0;
      r_shadow     <= '0;
      r_blink_cnt  <= '0;
      r_blink_off  <= 1'b0;
      r_row_n      <= 8'hFF;
      r_col        <= 8'h00;
      r_frame_sync <= 1'b0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_shadow     <= w_shadow_nxt;
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_blink_off  <= w_blink_off_nxt;
      r_row_n      <= w_row_n_nxt;
      r_col        <= w_col_nxt;
      r_frame_sync <= w_frame_sync_nxt;
    end
  end

  assign bus.row_n      = r_row_n;
  assign bus.col        = r_col;
  assign bus.frame_sync = r_frame_sync;

endmodule

// File: tb/tb_stacker_matrix_scan.sv
// Directed bench for stacker_matrix_scan with DWELL=4, BLANK=2, BLINK_FRAMES=2
// (48-cycle frames); expected scan pattern is derived from the cycle position.
module tb_stacker_matrix_scan;

  localparam int FRAME = 48;
  localparam int ROWP  = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   first_frame;

  stacker_matrix_scan_if bus ();

  stacker_matrix_scan #(
    .DWELL(4), .BLANK(2), .BLINK_FRAMES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.frame_valid = 1'b0;
    bus.frame_in    = '0;
    bus.blink_en    = 1'b0;
    tick();
    tick();
    rst         = 1'b1;
    first_frame = 1'b1;
  endtask

  // Runs len cycles from the start of a frame, checking every output each cycle.
  // Optional frame_valid pulses at positions pa/pb and a blink_en drop at drop_at.
  task automatic run_frame(input string tag, input logic [63:0] exp_frame, input int len,
                           input int pa, input logic [63:0] da,
                           input int pb, input logic [63:0] db,
                           input int drop_at);
    logic [7:0] one;
    logic [7:0] exp_rn, exp_col;
    logic       exp_fs;
    int         row;
    bit         drive;
    one = 8'd1;
    for (int p = 0; p < len; p++) begin
      row     = p / ROWP;
      drive   = (p % ROWP) >= 2;
      exp_rn  = drive ? ~(one << row) : 8'hFF;
      exp_col = drive ? exp_frame[8*row +: 8] : 8'h00;
      exp_fs  = (p == 0) && !first_frame;
      check($sformatf("%s.%0d row_n", tag, p), 64'(bus.row_n), 64'(exp_rn));
      check($sformatf("%s.%0d col", tag, p), 64'(bus.col), 64'(exp_col));
      check($sformatf("%s.%0d frame_sync", tag, p), 64'(bus.frame_sync), 64'(exp_fs));
      first_frame     = 1'b0;
      bus.frame_valid = (p == pa) || (p == pb);
      bus.frame_in    = (p == pb) ? db : da;
      if (p == drop_at) bus.blink_en = 1'b0;
      tick();
    end
    bus.frame_valid = 1'b0;
  endtask

  localparam logic [63:0] DIAG  = 64'h8040201008040201;
  localparam logic [63:0] ONES  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] PAT_B = 64'h00000000000000AA;
  localparam logic [63:0] PAT_C = 64'h0000000000000003;
  localparam logic [63:0] PAT_P = 64'h1122334455667788;
  localparam logic [63:0] PAT_Q = 64'hDEADBEEFCAFEF00D;

  initial begin
    // Reset and idle: blank scan of zeros, frame_sync only at the boundary
    do_reset();
    run_frame("idle1", '0, FRAME, -1, '0, -1, '0, -1);
    run_frame("idle2", '0, 1, -1, '0, -1, '0, -1);

    // Single load mid-frame appears one frame later
    do_reset();
    run_frame("diag1", '0, FRAME, 10, DIAG, -1, '0, -1);
    run_frame("diag2", DIAG, FRAME, -1, '0, -1, '0, -1);

    // Two loads in one frame: last write wins
    do_reset();
    run_frame("lww1", '0, FRAME, 5, ONES, 30, PAT_B, -1);
    run_frame("lww2", PAT_B, FRAME, -1, '0, -1, '0, -1);

    // Load exactly on the boundary edge bypasses the pending buffer
    do_reset();
    run_frame("byp1", '0, FRAME, 20, ONES, 47, PAT_C, -1);
    run_frame("byp2", PAT_C, FRAME, -1, '0, -1, '0, -1);
    run_frame("byp3", PAT_C, FRAME, -1, '0, -1, '0, -1);

    // Blink: pairs of on/off frames, then drop blink_en mid-off phase
    do_reset();
    run_frame("blk1", '0, FRAME, 3, ONES, -1, '0, -1);
    bus.blink_en = 1'b1;
    run_frame("blk2", ONES, FRAME, -1, '0, -1, '0, -1);
    run_frame("blk3", ONES, FRAME, -1, '0, -1, '0, -1);
    run_frame("blk4", '0, FRAME, -1, '0, -1, '0, -1);
    run_frame("blk5", '0, FRAME, -1, '0, -1, '0, -1);
    run_frame("blk6", ONES, FRAME, -1, '0, -1, '0, -1);
    run_frame("blk7", ONES, FRAME, -1, '0, -1, '0, -1);
    run_frame("blk8", 64'hFFFFFFFFFF000000, FRAME, -1, '0, -1, '0, 19);
    run_frame("blk9", ONES, FRAME, -1, '0, -1, '0, -1);

    // Reset during row 3 drive discards shadow and pending, restarts at row 0
    do_reset();
    run_frame("rst1", '0, FRAME, 8, PAT_P, -1, '0, -1);
    run_frame("rst2", PAT_P, 22, 5, PAT_Q, -1, '0, -1);
    rst = 1'b0;
    tick();
    check("rst_mid row_n", 64'(bus.row_n), 64'(8'hFF));
    check("rst_mid col", 64'(bus.col), 64'(8'h00));
    check("rst_mid frame_sync", 64'(bus.frame_sync), 64'(1'b0));
    rst         = 1'b1;
    first_frame = 1'b1;
    run_frame("rst3", '0, FRAME, -1, '0, -1, '0, -1);
    run_frame("rst4", '0, FRAME, -1, '0, -1, '0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
